iter_alu: RTL

- Parametrised, multi-cycle successor to the single-cycle integer ALU in riscv_core.
- Executes the RV32I base ALU ops plus the RV32M multiply/divide/remainder ops behind a valid/ready handshake.
- Single-cycle ops complete one cycle after acceptance. MUL*/DIV*/REM* iterate one bit per cycle.
- Sits in the execute stage. The pipeline stalls on in_ready/out_valid, and a kill input squashes in-flight work on a redirect.

---
 rtl/iter_alu.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle RV32IM integer ALU behind a valid/ready handshake.
// Base ALU ops resolve in one cycle. MUL*/DIV*/REM* iterate one bit per cycle
// on operand magnitudes and apply the sign fix on the last iteration.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;    // {hi, lo}: product, or {remainder, quotient}
    logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
    logic               neg_q, neg_d;    // negate product / quotient at the end
    logic               rneg_q, rneg_d;  // negate remainder at the end
    logic               hi_q, hi_d;      // return high product word / remainder
    logic [WIDTH-1:0]   out_q, out_d;

    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               is_mul, is_div, sgn1, sgn2, div0, ovf;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     sum, rem_sh, diff;
    logic [2*WIDTH-1:0] mul_nxt, mul_fix, div_nxt;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;

    // Single-cycle RV32I result straight from the live operands
    always_comb begin
        shamt   = rs2[SHW-1:0];
        alu_res = rs1 + rs2;
        case (op)
            5'd1:    alu_res = rs1 - rs2;
            5'd2:    alu_res = rs1 << shamt;
            5'd3:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            5'd4:    alu_res = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
            5'd5:    alu_res = rs1 ^ rs2;
            5'd6:    alu_res = rs1 >> shamt;
            5'd7:    alu_res = $unsigned($signed(rs1) >>> shamt);
            5'd8:    alu_res = rs1 | rs2;
            5'd9:    alu_res = rs1 & rs2;
            default: alu_res = rs1 + rs2;
        endcase
    end

    // Operand classification and magnitudes taken at acceptance
    always_comb begin
        is_mul = (op >= 5'd10) && (op <= 5'd13);
        is_div = (op >= 5'd14) && (op <= 5'd17);
        sgn1   = rs1[WIDTH-1] && (op == 5'd11 || op == 5'd12 || op == 5'd14 || op == 5'd16);
        sgn2   = rs2[WIDTH-1] && (op == 5'd11 || op == 5'd14 || op == 5'd16);
        mag1   = sgn1 ? (-rs1) : rs1;
        mag2   = sgn2 ? (-rs2) : rs2;
        div0   = (rs2 == '0);
        ovf    = (op == 5'd14 || op == 5'd16) && (rs1 == MOST_NEG) && (rs2 == '1);
    end

    // One shift-add and one restoring-division step per cycle
    always_comb begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt = {sum, acc_q[WIDTH-1:1]};
        mul_fix = neg_q ? (-mul_nxt) : mul_nxt;
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opnd_q};
        // A borrow out of the top bit means the trial subtract failed: restore
        div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
        quo_fix = neg_q  ? (-div_nxt[WIDTH-1:0])       : div_nxt[WIDTH-1:0];
        rem_fix = rneg_q ? (-div_nxt[2*WIDTH-1:WIDTH]) : div_nxt[2*WIDTH-1:WIDTH];
    end

    // Next-state: accept, iterate, hold result; kill overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cnt_d = '0;
                    if (is_mul) begin
                        state_d = S_MUL;
                        acc_d   = {{WIDTH{1'b0}}, mag2};
                        opnd_d  = mag1;
                        neg_d   = sgn1 ^ sgn2;
                        hi_d    = (op != 5'd10);
                    end else if (is_div && div0) begin
                        state_d = S_DONE;
                        out_d   = (op == 5'd14 || op == 5'd15) ? '1 : rs1;
                    end else if (is_div && ovf) begin
                        state_d = S_DONE;
                        out_d   = (op == 5'd14) ? rs1 : '0;
                    end else if (is_div) begin
                        state_d = S_DIV;
                        acc_d   = {{WIDTH{1'b0}}, mag1};
                        opnd_d  = mag2;
                        neg_d   = sgn1 ^ sgn2;
                        rneg_d  = sgn1;
                        hi_d    = (op == 5'd16 || op == 5'd17);
                    end else begin
                        state_d = S_DONE;
                        out_d   = alu_res;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    out_d   = hi_q ? mul_fix[2*WIDTH-1:WIDTH] : mul_fix[WIDTH-1:0];
                end
            end
            S_DIV: begin
                acc_d = div_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    out_d   = hi_q ? rem_fix : quo_fix;
                end
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
        // A killed op never updates out, even on its final iteration
        if (kill) begin
            state_d = S_IDLE;
            out_d   = out_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            out_q   <= out_d;
        end
    end

endmodule
